// File: rtl/five_stage_control_unit_pkg.sv
// Shared definitions for the five-stage pipeline control unit.
//   - RV32 base opcodes seen by the decoder and hazard logic
//   - bypass source codes, next-PC select, operand/extend select encodings
//   - bypass_select(): priority forwarding pick for one decode source
package five_stage_control_unit_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic [1:0] {
      BYPASS_REGFILE   = 2'b00,
      BYPASS_EXECUTE   = 2'b01,
      BYPASS_MEMORY    = 2'b10,
      BYPASS_WRITEBACK = 2'b11
   } bypass_sel_t;

   typedef enum logic [1:0] {
      NPC_PLUS4  = 2'b00,
      NPC_BRANCH = 2'b01,
      NPC_JAL    = 2'b10,
      NPC_JALR   = 2'b11
   } next_pc_sel_t;

   typedef enum logic [1:0] {
      OPA_RS1  = 2'b00,
      OPA_PC   = 2'b01,
      OPA_PC4  = 2'b10,
      OPA_ZERO = 2'b11
   } opa_sel_t;

   localparam logic OPB_RS2 = 1'b0;
   localparam logic OPB_IMM = 1'b1;

   typedef enum logic [1:0] {
      EXT_I  = 2'b00,
      EXT_S  = 2'b01,
      EXT_U  = 2'b10,
      EXT_BJ = 2'b11
   } ext_sel_t;

   localparam logic [5:0] ALU_ADD    = 6'b000000;
   localparam logic [5:0] ALU_PASS_A = 6'b111111;

   // Youngest producer wins; x0 never forwards.
   function automatic bypass_sel_t bypass_select(
      input logic [4:0] src,
      input logic       used,
      input logic [4:0] rd_ex,
      input logic       we_ex,
      input logic [4:0] rd_mem,
      input logic       we_mem,
      input logic [4:0] rd_wb,
      input logic       we_wb
   );
      bypass_sel_t sel;
      sel = BYPASS_REGFILE;
      if (used && (src != 5'd0)) begin
         if (we_ex && (rd_ex == src))
            sel = BYPASS_EXECUTE;
         else if (we_mem && (rd_mem == src))
            sel = BYPASS_MEMORY;
         else if (we_wb && (rd_wb == src))
            sel = BYPASS_WRITEBACK;
      end
      return sel;
   endfunction

endpackage

// File: rtl/five_stage_control_unit_control_decoder.sv
// Decode-stage control word generation, purely combinational.
// Ports:
//   opcode, funct3, funct7_b5   decode-stage instruction fields
//   branch_op, memRead, memWrite, unsigned_load, regWrite   class flags
//   log2_bytes                  access size for loads/stores
//   ALU_operation               {2'b00, alt, funct3} / branch compare / pass-A
//   operand_A_sel, operand_B_sel, extend_sel   datapath mux selects
module five_stage_control_unit_control_decoder
   import five_stage_control_unit_pkg::*;
#(
   parameter int LOG2_NUM_BYTES = 2
) (
   input  logic [6:0]                opcode,
   input  logic [2:0]                funct3,
   input  logic                      funct7_b5,
   output logic                      branch_op,
   output logic                      memRead,
   output logic                      memWrite,
   output logic                      unsigned_load,
   output logic                      operand_B_sel,
   output logic                      regWrite,
   output logic [5:0]                ALU_operation,
   output logic [LOG2_NUM_BYTES-1:0] log2_bytes,
   output logic [1:0]                operand_A_sel,
   output logic [1:0]                extend_sel
);

   always_comb begin
      branch_op     = 1'b0;
      memRead       = 1'b0;
      memWrite      = 1'b0;
      unsigned_load = 1'b0;
      operand_B_sel = OPB_IMM;
      regWrite      = 1'b0;
      ALU_operation = ALU_ADD;
      log2_bytes    = '0;
      operand_A_sel = OPA_RS1;
      extend_sel    = EXT_I;
      case (opcode)
         OP_R: begin
            regWrite      = 1'b1;
            operand_B_sel = OPB_RS2;
            ALU_operation = {2'b00, funct7_b5, funct3};
         end
         OP_I: begin
            regWrite      = 1'b1;
            // funct7[5] only distinguishes SRAI from SRLI; for other I-ops it is immediate bits.
            ALU_operation = {2'b00, funct7_b5 & (funct3 == 3'b101), funct3};
         end
         OP_STORE: begin
            memWrite   = 1'b1;
            log2_bytes = LOG2_NUM_BYTES'(funct3[1:0]);
            extend_sel = EXT_S;
         end
         OP_LOAD: begin
            memRead       = 1'b1;
            regWrite      = 1'b1;
            log2_bytes    = LOG2_NUM_BYTES'(funct3[1:0]);
            unsigned_load = funct3[2];
         end
         OP_BRANCH: begin
            branch_op     = 1'b1;
            operand_B_sel = OPB_RS2;
            extend_sel    = EXT_BJ;
            ALU_operation = {3'b010, funct3};
         end
         OP_JALR: begin
            regWrite      = 1'b1;
            operand_A_sel = OPA_PC4;
            ALU_operation = ALU_PASS_A;
         end
         OP_JAL: begin
            regWrite      = 1'b1;
            operand_A_sel = OPA_PC4;
            extend_sel    = EXT_BJ;
            ALU_operation = ALU_PASS_A;
         end
         OP_LUI: begin
            regWrite      = 1'b1;
            operand_A_sel = OPA_ZERO;
            extend_sel    = EXT_U;
         end
         OP_AUIPC: begin
            regWrite      = 1'b1;
            operand_A_sel = OPA_PC;
            extend_sel    = EXT_U;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/five_stage_control_unit.sv
// Pipeline control for a five-stage in-order core: decode control word,
// next-PC redirect, load-use / memory-wait hazards, operand forwarding and a
// cycle counter used to window diagnostic scan prints.
// Ports:
//   clock, reset (async, active-low)
//   opcode_*/funct*/rs*/rd_*/regWrite_*   pipeline stage fields
//   *_target_*, branch_execute            redirect sources
//   fetch_*/memory_*/load_*/store_*       memory handshake status
//   scan                                  enable diagnostic print
//   decode control outputs, next_PC_sel/target_PC, i_mem_read,
//   stall_*/flush_*, rs1/rs2_data_bypass
module five_stage_control_unit
   import five_stage_control_unit_pkg::*;
#(
   parameter int CORE            = 0,
   parameter int ADDRESS_BITS    = 20,
   parameter int NUM_BYTES       = 4,
   parameter int LOG2_NUM_BYTES  = $clog2(NUM_BYTES),
   parameter int SCAN_CYCLES_MIN = 0,
   parameter int SCAN_CYCLES_MAX = 1000
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [6:0]                opcode_decode,
   input  logic [6:0]                opcode_execute,
   input  logic [6:0]                opcode_memory,
   input  logic [2:0]                funct3,
   input  logic [6:0]                funct7,
   input  logic [ADDRESS_BITS-1:0]   JALR_target_execute,
   input  logic [ADDRESS_BITS-1:0]   branch_target_execute,
   input  logic [ADDRESS_BITS-1:0]   JAL_target_decode,
   input  logic                      branch_execute,
   input  logic [4:0]                rs1,
   input  logic [4:0]                rs2,
   input  logic [4:0]                rd_execute,
   input  logic [4:0]                rd_memory,
   input  logic [4:0]                rd_writeback,
   input  logic                      regWrite_execute,
   input  logic                      regWrite_memory,
   input  logic                      regWrite_writeback,
   input  logic                      fetch_valid,
   input  logic                      fetch_ready,
   input  logic                      memory_valid,
   input  logic                      memory_ready,
   input  logic                      load_memory,
   input  logic                      store_memory,
   input  logic                      scan,
   input  logic [ADDRESS_BITS-1:0]   issue_PC,
   input  logic [ADDRESS_BITS-1:0]   fetch_address_in,
   input  logic [ADDRESS_BITS-1:0]   load_address,
   input  logic [ADDRESS_BITS-1:0]   memory_address_in,
   output logic                      branch_op,
   output logic                      memRead,
   output logic                      memWrite,
   output logic                      unsigned_load,
   output logic                      operand_B_sel,
   output logic                      regWrite,
   output logic [5:0]                ALU_operation,
   output logic [LOG2_NUM_BYTES-1:0] log2_bytes,
   output logic [1:0]                next_PC_sel,
   output logic [1:0]                operand_A_sel,
   output logic [1:0]                extend_sel,
   output logic [ADDRESS_BITS-1:0]   target_PC,
   output logic                      i_mem_read,
   output logic                      stall_decode,
   output logic                      stall_execute,
   output logic                      stall_memory,
   output logic                      flush_decode,
   output logic                      flush_execute,
   output logic                      flush_writeback,
   output logic [1:0]                rs1_data_bypass,
   output logic [1:0]                rs2_data_bypass
);

   logic        rs1_used;
   logic        rs2_used;
   logic        load_use;
   logic        jb_exec;
   logic        jal_dec;
   logic        imem_hz;
   logic        dmem_hz;
   logic [31:0] cycle_count;

   five_stage_control_unit_control_decoder #(
      .LOG2_NUM_BYTES (LOG2_NUM_BYTES)
   ) u_control_decoder (
      .opcode        (opcode_decode),
      .funct3        (funct3),
      .funct7_b5     (funct7[5]),
      .branch_op     (branch_op),
      .memRead       (memRead),
      .memWrite      (memWrite),
      .unsigned_load (unsigned_load),
      .operand_B_sel (operand_B_sel),
      .regWrite      (regWrite),
      .ALU_operation (ALU_operation),
      .log2_bytes    (log2_bytes),
      .operand_A_sel (operand_A_sel),
      .extend_sel    (extend_sel)
   );

   // Memory-stage jumps already redirected from execute/decode; memory opcode,
   // fetch_ready and most funct7 bits carry no control meaning here.
   logic unused_ok;
   assign unused_ok = &{1'b0, opcode_memory, fetch_ready, funct7[6], funct7[4:0]};

   always_comb begin
      rs1_used = !((opcode_decode == OP_JAL) || (opcode_decode == OP_LUI) ||
                   (opcode_decode == OP_AUIPC));
      rs2_used = (opcode_decode == OP_R) || (opcode_decode == OP_STORE) ||
                 (opcode_decode == OP_BRANCH);
   end

   always_comb begin
      load_use = (opcode_execute == OP_LOAD) && regWrite_execute && (rd_execute != 5'd0) &&
                 ((rs1_used && (rd_execute == rs1)) || (rs2_used && (rd_execute == rs2)));
      jb_exec  = (opcode_execute == OP_JALR) ||
                 ((opcode_execute == OP_BRANCH) && branch_execute);
      jal_dec  = (opcode_decode == OP_JAL);
      imem_hz  = !fetch_valid || (issue_PC != fetch_address_in);
      dmem_hz  = ((load_memory || store_memory) && !memory_ready) ||
                 (load_memory && (!memory_valid || (load_address != memory_address_in)));
   end

   always_comb begin
      next_PC_sel = NPC_PLUS4;
      target_PC   = '0;
      if (opcode_execute == OP_JALR) begin
         next_PC_sel = NPC_JALR;
         target_PC   = JALR_target_execute;
      end else if ((opcode_execute == OP_BRANCH) && branch_execute) begin
         next_PC_sel = NPC_BRANCH;
         target_PC   = branch_target_execute;
      end else if (jal_dec) begin
         next_PC_sel = NPC_JAL;
         target_PC   = JAL_target_decode;
      end
   end

   // A data-memory wait freezes everything upstream and suppresses flushes so
   // the redirect is taken once the memory stage drains.
   always_comb begin
      stall_memory    = dmem_hz;
      stall_execute   = dmem_hz;
      flush_writeback = dmem_hz;
      stall_decode    = dmem_hz || load_use;
      flush_execute   = !dmem_hz && (load_use || jb_exec);
      flush_decode    = !dmem_hz && (jb_exec || (!load_use && (jal_dec || imem_hz)));
      i_mem_read      = reset && !stall_decode;
   end

   // A load in execute cannot forward yet; the bubble makes it a memory-stage hit next cycle.
   always_comb begin
      rs1_data_bypass = BYPASS_REGFILE;
      rs2_data_bypass = BYPASS_REGFILE;
      if (!load_use) begin
         rs1_data_bypass = bypass_select(rs1, rs1_used, rd_execute, regWrite_execute,
                                         rd_memory, regWrite_memory,
                                         rd_writeback, regWrite_writeback);
         rs2_data_bypass = bypass_select(rs2, rs2_used, rd_execute, regWrite_execute,
                                         rd_memory, regWrite_memory,
                                         rd_writeback, regWrite_writeback);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         cycle_count <= '0;
      else
         cycle_count <= cycle_count + 32'd1;
   end

`ifndef SYNTHESIS
   // Signed compare keeps the window check meaningful for any MIN, including 0.
   localparam logic signed [32:0] SCAN_LO = 33'(SCAN_CYCLES_MIN);
   localparam logic signed [32:0] SCAN_HI = 33'(SCAN_CYCLES_MAX);
   logic signed [32:0] count_s;
   assign count_s = {1'b0, cycle_count};

   always @(posedge clock) begin
      if (scan && (count_s >= SCAN_LO) && (count_s <= SCAN_HI)) begin
         $display("core %0d cycle %0d | stall d/e/m %b%b%b flush d/e/w %b%b%b bypass rs1 %b rs2 %b | next_PC_sel %b",
                  CORE, cycle_count, stall_decode, stall_execute, stall_memory,
                  flush_decode, flush_execute, flush_writeback,
                  rs1_data_bypass, rs2_data_bypass, next_PC_sel);
      end
   end
`endif

endmodule

// File: tb/tb_five_stage_control_unit.sv
module tb_five_stage_control_unit;

   localparam int AB = 20;

   logic          clock = 1'b0;
   logic          reset;
   logic [6:0]    opcode_decode, opcode_execute, opcode_memory;
   logic [2:0]    funct3;
   logic [6:0]    funct7;
   logic [AB-1:0] JALR_target_execute, branch_target_execute, JAL_target_decode;
   logic          branch_execute;
   logic [4:0]    rs1, rs2, rd_execute, rd_memory, rd_writeback;
   logic          regWrite_execute, regWrite_memory, regWrite_writeback;
   logic          fetch_valid, fetch_ready, memory_valid, memory_ready;
   logic          load_memory, store_memory, scan;
   logic [AB-1:0] issue_PC, fetch_address_in, load_address, memory_address_in;
   logic          branch_op, memRead, memWrite, unsigned_load, operand_B_sel, regWrite;
   logic [5:0]    ALU_operation;
   logic [1:0]    log2_bytes;
   logic [1:0]    next_PC_sel, operand_A_sel, extend_sel;
   logic [AB-1:0] target_PC;
   logic          i_mem_read;
   logic          stall_decode, stall_execute, stall_memory;
   logic          flush_decode, flush_execute, flush_writeback;
   logic [1:0]    rs1_data_bypass, rs2_data_bypass;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   five_stage_control_unit dut (
      .clock(clock), .reset(reset),
      .opcode_decode(opcode_decode), .opcode_execute(opcode_execute), .opcode_memory(opcode_memory),
      .funct3(funct3), .funct7(funct7),
      .JALR_target_execute(JALR_target_execute), .branch_target_execute(branch_target_execute),
      .JAL_target_decode(JAL_target_decode), .branch_execute(branch_execute),
      .rs1(rs1), .rs2(rs2), .rd_execute(rd_execute), .rd_memory(rd_memory), .rd_writeback(rd_writeback),
      .regWrite_execute(regWrite_execute), .regWrite_memory(regWrite_memory),
      .regWrite_writeback(regWrite_writeback),
      .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .memory_valid(memory_valid),
      .memory_ready(memory_ready), .load_memory(load_memory), .store_memory(store_memory), .scan(scan),
      .issue_PC(issue_PC), .fetch_address_in(fetch_address_in), .load_address(load_address),
      .memory_address_in(memory_address_in),
      .branch_op(branch_op), .memRead(memRead), .memWrite(memWrite), .unsigned_load(unsigned_load),
      .operand_B_sel(operand_B_sel), .regWrite(regWrite), .ALU_operation(ALU_operation),
      .log2_bytes(log2_bytes), .next_PC_sel(next_PC_sel), .operand_A_sel(operand_A_sel),
      .extend_sel(extend_sel), .target_PC(target_PC), .i_mem_read(i_mem_read),
      .stall_decode(stall_decode), .stall_execute(stall_execute), .stall_memory(stall_memory),
      .flush_decode(flush_decode), .flush_execute(flush_execute), .flush_writeback(flush_writeback),
      .rs1_data_bypass(rs1_data_bypass), .rs2_data_bypass(rs2_data_bypass)
   );

   task automatic check_value(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      if (observed !== expected) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // ---------------- reference model ----------------
   typedef enum int {K_R, K_I, K_ST, K_LD, K_BR, K_JALR, K_JAL, K_LUI, K_AUIPC, K_OTHER} kind_t;

   logic [6:0] op_table [9] = '{7'b0110011, 7'b0010011, 7'b0100011, 7'b0000011, 7'b1100011,
                                7'b1100111, 7'b1101111, 7'b0110111, 7'b0010111};

   function automatic kind_t kind_of(input logic [6:0] op);
      for (int k = 0; k < 9; k++)
         if (op == op_table[k]) return kind_t'(k);
      return K_OTHER;
   endfunction

   task automatic check_all(input string ctx);
      kind_t d, e;
      int    a_sel, b_sel, ext, alu, l2b, npc, bp1, bp2;
      bit    writes, rs1_used, rs2_used, lu, jb, jal, ihz, dhz;
      logic [AB-1:0] tgt;
      int    rd_s [3];
      bit    we_s [3];

      d = kind_of(opcode_decode);
      e = kind_of(opcode_execute);

      writes = d inside {K_R, K_I, K_LD, K_JAL, K_JALR, K_LUI, K_AUIPC};
      l2b    = (d == K_LD || d == K_ST) ? int'(funct3) % 4 : 0;
      a_sel  = (d == K_AUIPC) ? 1 : (d == K_JAL || d == K_JALR) ? 2 : (d == K_LUI) ? 3 : 0;
      b_sel  = (d == K_R || d == K_BR) ? 0 : 1;
      ext    = (d == K_ST) ? 1 : (d == K_LUI || d == K_AUIPC) ? 2 : (d == K_BR || d == K_JAL) ? 3 : 0;
      case (d)
         K_R:          alu = 8 * int'(funct7[5]) + int'(funct3);
         K_I:          alu = ((funct7[5] && funct3 == 3'd5) ? 8 : 0) + int'(funct3);
         K_BR:         alu = 16 + int'(funct3);
         K_JAL, K_JALR: alu = 63;
         default:      alu = 0;
      endcase

      rs1_used = !(d inside {K_JAL, K_LUI, K_AUIPC});
      rs2_used = d inside {K_R, K_ST, K_BR};
      lu  = (e == K_LD) && regWrite_execute && rd_execute != 0 &&
            ((rs1_used && rd_execute == rs1) || (rs2_used && rd_execute == rs2));
      jb  = (e == K_JALR) || (e == K_BR && branch_execute);
      jal = (d == K_JAL);
      ihz = !fetch_valid || issue_PC != fetch_address_in;
      dhz = ((load_memory || store_memory) && !memory_ready) ||
            (load_memory && (!memory_valid || load_address != memory_address_in));

      if (e == K_JALR)                    begin npc = 3; tgt = JALR_target_execute;   end
      else if (e == K_BR && branch_execute) begin npc = 1; tgt = branch_target_execute; end
      else if (jal)                       begin npc = 2; tgt = JAL_target_decode;     end
      else                                begin npc = 0; tgt = '0;                    end

      rd_s = '{int'(rd_execute), int'(rd_memory), int'(rd_writeback)};
      we_s = '{regWrite_execute, regWrite_memory, regWrite_writeback};
      bp1 = 0; bp2 = 0;
      if (!lu) begin
         for (int s = 2; s >= 0; s--) begin
            if (we_s[s] && rs1_used && rs1 != 0 && rd_s[s] == int'(rs1)) bp1 = s + 1;
            if (we_s[s] && rs2_used && rs2 != 0 && rd_s[s] == int'(rs2)) bp2 = s + 1;
         end
      end

      check_value({ctx, ".branch_op"},     32'(branch_op),     32'(d == K_BR));
      check_value({ctx, ".memRead"},       32'(memRead),       32'(d == K_LD));
      check_value({ctx, ".memWrite"},      32'(memWrite),      32'(d == K_ST));
      check_value({ctx, ".regWrite"},      32'(regWrite),      32'(writes));
      check_value({ctx, ".unsigned_load"}, 32'(unsigned_load), 32'(d == K_LD && funct3[2]));
      check_value({ctx, ".log2_bytes"},    32'(log2_bytes),    32'(l2b));
      check_value({ctx, ".opA"},           32'(operand_A_sel), 32'(a_sel));
      check_value({ctx, ".opB"},           32'(operand_B_sel), 32'(b_sel));
      check_value({ctx, ".extend"},        32'(extend_sel),    32'(ext));
      check_value({ctx, ".alu"},           32'(ALU_operation), 32'(alu));
      check_value({ctx, ".next_PC_sel"},   32'(next_PC_sel),   32'(npc));
      check_value({ctx, ".target_PC"},     32'(target_PC),     32'(tgt));
      check_value({ctx, ".stall_d"},       32'(stall_decode),  32'(dhz || lu));
      check_value({ctx, ".stall_e"},       32'(stall_execute), 32'(dhz));
      check_value({ctx, ".stall_m"},       32'(stall_memory),  32'(dhz));
      check_value({ctx, ".flush_w"},       32'(flush_writeback), 32'(dhz));
      check_value({ctx, ".flush_e"},       32'(flush_execute), 32'(!dhz && (lu || jb)));
      check_value({ctx, ".flush_d"},       32'(flush_decode),  32'(!dhz && (jb || (!lu && (jal || ihz)))));
      check_value({ctx, ".i_mem_read"},    32'(i_mem_read),    32'(reset && !(dhz || lu)));
      check_value({ctx, ".bypass1"},       32'(rs1_data_bypass), 32'(bp1));
      check_value({ctx, ".bypass2"},       32'(rs2_data_bypass), 32'(bp2));
   endtask

   // ---------------- stimulus ----------------
   task automatic set_quiet();
      opcode_decode = 7'b0110011; opcode_execute = 7'b0110011; opcode_memory = 7'b0110011;
      funct3 = 3'd0; funct7 = 7'd0;
      JALR_target_execute = 20'h1A2B4; branch_target_execute = 20'h0C0C0; JAL_target_decode = 20'h3F004;
      branch_execute = 1'b0;
      rs1 = 5'd10; rs2 = 5'd11; rd_execute = 5'd20; rd_memory = 5'd21; rd_writeback = 5'd22;
      regWrite_execute = 1'b0; regWrite_memory = 1'b0; regWrite_writeback = 1'b0;
      fetch_valid = 1'b1; fetch_ready = 1'b1; memory_valid = 1'b1; memory_ready = 1'b1;
      load_memory = 1'b0; store_memory = 1'b0; scan = 1'b0;
      issue_PC = 20'h00100; fetch_address_in = 20'h00100;
      load_address = 20'h00200; memory_address_in = 20'h00200;
   endtask

   function automatic logic [6:0] rand_op();
      int k = $urandom_range(0, 10);
      if (k >= 9) return 7'($urandom);
      return op_table[k];
   endfunction

   task automatic settle();
      @(negedge clock);
   endtask

   initial begin
      reset = 1'b0;
      set_quiet();
      #1;
      check_value("reset.i_mem_read", 32'(i_mem_read), 32'd0);
      check_all("reset");
      settle(); settle();
      reset = 1'b1;
      #1;
      check_value("quiet.i_mem_read", 32'(i_mem_read), 32'd1);
      check_all("quiet");

      // load-use on rs1 with an R-type in decode
      settle(); set_quiet();
      rs1 = 5'd1; rd_execute = 5'd1; regWrite_execute = 1'b1; opcode_execute = 7'b0000011;
      #1;
      check_value("lu.stall_d", 32'(stall_decode), 32'd1);
      check_value("lu.flush_e", 32'(flush_execute), 32'd1);
      check_value("lu.flush_d", 32'(flush_decode), 32'd0);
      check_value("lu.bypass1", 32'(rs1_data_bypass), 32'd0);
      check_all("lu");

      // fetch not valid
      settle(); set_quiet(); fetch_valid = 1'b0;
      #1;
      check_value("imem.flush_d", 32'(flush_decode), 32'd1);
      check_all("imem");

      // store waiting on memory
      settle(); set_quiet(); store_memory = 1'b1; memory_ready = 1'b0;
      #1;
      check_value("dmem.stall_d", 32'(stall_decode), 32'd1);
      check_value("dmem.flush_w", 32'(flush_writeback), 32'd1);
      check_value("dmem.flush_d", 32'(flush_decode), 32'd0);
      check_all("dmem");

      // JALR in execute, JAL in memory
      settle(); set_quiet(); opcode_execute = 7'b1100111; opcode_memory = 7'b1101111;
      #1;
      check_value("jalr.npc", 32'(next_PC_sel), 32'd3);
      check_value("jalr.target", 32'(target_PC), 32'h1A2B4);
      check_all("jalr");

      // JAL in execute / JALR in memory do nothing
      settle(); set_quiet(); opcode_execute = 7'b1101111; opcode_memory = 7'b1100111;
      #1;
      check_value("jalx.flush_d", 32'(flush_decode), 32'd0);
      check_value("jalx.flush_e", 32'(flush_execute), 32'd0);
      check_all("jalx");

      // JAL in decode
      settle(); set_quiet(); opcode_decode = 7'b1101111;
      #1;
      check_value("jal.npc", 32'(next_PC_sel), 32'd2);
      check_value("jal.target", 32'(target_PC), 32'h3F004);
      check_all("jal");

      // bypass patterns
      settle(); set_quiet(); opcode_decode = 7'b0010011; rs1 = 5'd1; rd_execute = 5'd1; regWrite_execute = 1'b1;
      #1;
      check_value("byp_ex.rs1", 32'(rs1_data_bypass), 32'd1);
      check_all("byp_ex");

      settle(); set_quiet(); rs2 = 5'd1; rd_memory = 5'd1; regWrite_memory = 1'b1;
      #1;
      check_value("byp_mem.rs2", 32'(rs2_data_bypass), 32'd2);
      check_all("byp_mem");

      settle(); set_quiet(); rs1 = 5'd1; rs2 = 5'd2; rd_memory = 5'd1; rd_writeback = 5'd2;
      regWrite_memory = 1'b1; regWrite_writeback = 1'b1;
      #1;
      check_value("byp_mw.rs1", 32'(rs1_data_bypass), 32'd2);
      check_value("byp_mw.rs2", 32'(rs2_data_bypass), 32'd3);
      check_all("byp_mw");

      // x0 never forwards
      settle(); set_quiet(); rs1 = 5'd0; rd_execute = 5'd0; regWrite_execute = 1'b1;
      #1;
      check_value("x0.rs1", 32'(rs1_data_bypass), 32'd0);
      check_all("x0");

      // short scan window exercise
      settle(); set_quiet(); scan = 1'b1;
      settle(); scan = 1'b0;

      // randomized
      for (int it = 0; it < 400; it++) begin
         settle();
         opcode_decode  = rand_op();
         opcode_execute = rand_op();
         opcode_memory  = rand_op();
         funct3 = 3'($urandom); funct7 = 7'($urandom);
         JALR_target_execute = AB'($urandom); branch_target_execute = AB'($urandom);
         JAL_target_decode = AB'($urandom);
         branch_execute = 1'($urandom);
         rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3));
         rd_execute = 5'($urandom_range(0, 3)); rd_memory = 5'($urandom_range(0, 3));
         rd_writeback = 5'($urandom_range(0, 3));
         regWrite_execute = 1'($urandom); regWrite_memory = 1'($urandom);
         regWrite_writeback = 1'($urandom);
         fetch_valid  = ($urandom_range(0, 7) != 0);
         fetch_ready  = 1'($urandom);
         memory_valid = ($urandom_range(0, 7) != 0);
         memory_ready = ($urandom_range(0, 5) != 0);
         load_memory  = ($urandom_range(0, 3) == 0);
         store_memory = ($urandom_range(0, 3) == 0);
         issue_PC = AB'($urandom);
         fetch_address_in  = ($urandom_range(0, 7) != 0) ? issue_PC : AB'($urandom);
         load_address = AB'($urandom);
         memory_address_in = ($urandom_range(0, 7) != 0) ? load_address : AB'($urandom);
         if (it == 200) reset = 1'b0;
         if (it == 205) reset = 1'b1;
         #1;
         check_all("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
